// File: rtl/elink_tx_gearbox_if.sv
// Word-side handshake between the encoder/FIFO read side and the e-link gearbox.
// Ports: tx_en (link enable), din (10-bit 8b10b word, bit 0 = 'a'),
//        din_valid (din offered), din_ready (gearbox takes din this cycle).
interface elink_tx_gearbox_if;
  logic       tx_en;
  logic [9:0] din;
  logic       din_valid;
  logic       din_ready;

  // Word source (encoder / FIFO read side).
  modport master (
    output tx_en,
    output din,
    output din_valid,
    input  din_ready
  );

  // Gearbox side.
  modport slave (
    input  tx_en,
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/elink_tx_gearbox.sv
// Purpose: 10b-word to ELINK_WIDTH-bit serial gearbox with disparity-aware K28.5 idle fill.
// Latency: a word loaded into an empty buffer at edge k shows its first slice after edge k+1.
// Backpressure: din_ready is combinational and only high on cycles where a word is appended.
//
// Ports:
//   bitCLK      - e-link bit-group clock
//   rst         - asynchronous active-high reset
//   din_if      - slave side of elink_tx_gearbox_if (tx_en, din, din_valid, din_ready)
//   elink_out   - registered serial slice, ELINK_WIDTH bits per cycle
//   idle_active - last loaded word was an idle comma
//   rd_state    - running disparity after the last load (0 = RD-, 1 = RD+)
//   code_err    - sticky: a loaded word had a ones-count outside {4,5,6}
// Optional build macro ELINK_TX_STATS_EN adds:
//   stats_clr   - synchronous clear of both counters (wins over increment)
//   data_cnt    - saturating count of data loads
//   idle_cnt    - saturating count of idle loads
module elink_tx_gearbox #(
  parameter int         ELINK_WIDTH = 2,
  parameter bit         MSB_FIRST   = 1'b0,
  parameter logic [9:0] IDLE_RDN    = 10'h17C,
  parameter logic [9:0] IDLE_RDP    = 10'h283
) (
  input  logic                    bitCLK,
  input  logic                    rst,
  elink_tx_gearbox_if.slave       din_if,
  output logic [ELINK_WIDTH-1:0]  elink_out,
  output logic                    idle_active,
  output logic                    rd_state,
  output logic                    code_err
`ifdef ELINK_TX_STATS_EN
  ,
  input  logic                    stats_clr,
  output logic [15:0]             data_cnt,
  output logic [15:0]             idle_cnt
`endif
);

  localparam int         W  = ELINK_WIDTH;
  localparam logic [4:0] W5 = 5'(ELINK_WIDTH);

  generate
    if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_width
      $error("elink_tx_gearbox: ELINK_WIDTH must be 1, 2, 4 or 8");
    end
  endgenerate

  // Shift buffer: bit 0 is the next bit on the wire. Worst case holds W-1 leftover
  // bits plus a fresh 10-bit word, i.e. 17 bits.
  logic [17:0]  sbuf;
  logic [17:0]  sbuf_sh;
  logic [17:0]  sbuf_nxt;
  logic [4:0]   fill;
  logic [4:0]   fill_n;
  logic [4:0]   fill_nxt;
  logic         emit;
  logic         load;
  logic         take_data;
  logic [9:0]   word;
  logic [3:0]   word_ones;
  logic         word_bad;
  logic [W-1:0] slice_o;

  function automatic logic [3:0] ones10(input logic [9:0] w);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) begin
      n = n + {3'd0, w[i]};
    end
    return n;
  endfunction

  // Emit first, then top up: loading only once fewer than W bits remain keeps the
  // output gap-free while never letting the buffer exceed 17 bits.
  always_comb begin
    emit      = 1'b0;
    sbuf_sh   = sbuf;
    fill_n    = fill;
    load      = 1'b0;
    take_data = 1'b0;
    word      = IDLE_RDN;
    sbuf_nxt  = sbuf;
    fill_nxt  = fill;

    emit = (fill >= W5);
    if (emit) begin
      sbuf_sh = sbuf >> W;
      fill_n  = fill - W5;
    end

    load      = (fill_n < W5);
    take_data = din_if.tx_en && din_if.din_valid;
    if (take_data) begin
      word = din_if.din;
    end else begin
      // The comma polarity follows the disparity left by the previous word.
      word = rd_state ? IDLE_RDP : IDLE_RDN;
    end

    sbuf_nxt = sbuf_sh;
    fill_nxt = fill_n;
    if (load) begin
      // Bits above fill_n are already zero after the shift, so OR appends cleanly.
      sbuf_nxt = sbuf_sh | ({8'd0, word} << fill_n);
      fill_nxt = fill_n + 5'd10;
    end
  end

  assign word_ones        = ones10(word);
  assign word_bad         = (word_ones < 4'd4) || (word_ones > 4'd6);
  assign din_if.din_ready = din_if.tx_en && load;

  // MSB_FIRST mirrors the whole slice so the first bit on the wire lands on the top pin.
  generate
    for (genvar i = 0; i < W; i++) begin : g_order
      if (MSB_FIRST) begin : g_rev
        assign slice_o[i] = sbuf[W-1-i];
      end else begin : g_fwd
        assign slice_o[i] = sbuf[i];
      end
    end
  endgenerate

  always_ff @(posedge bitCLK or posedge rst) begin
    if (rst) begin
      sbuf        <= '0;
      fill        <= '0;
      elink_out   <= '0;
      idle_active <= 1'b0;
      rd_state    <= 1'b0;
      code_err    <= 1'b0;
    end else begin
      sbuf <= sbuf_nxt;
      fill <= fill_nxt;
      // Only the very first cycle after reset has nothing to emit; hold the pins then.
      if (emit) begin
        elink_out <= slice_o;
      end
      if (load) begin
        // Balanced words keep disparity; 4/6-ones words flip it. Illegal counts
        // also flip so the idle fill still alternates, and flag the error.
        rd_state    <= rd_state ^ (word_ones != 4'd5);
        idle_active <= !take_data;
        if (word_bad) begin
          code_err <= 1'b1;
        end
      end
    end
  end

`ifdef ELINK_TX_STATS_EN
  always_ff @(posedge bitCLK or posedge rst) begin
    if (rst) begin
      data_cnt <= '0;
      idle_cnt <= '0;
    end else if (stats_clr) begin
      data_cnt <= '0;
      idle_cnt <= '0;
    end else if (load) begin
      if (take_data && data_cnt != 16'hFFFF) begin
        data_cnt <= data_cnt + 16'd1;
      end
      if (!take_data && idle_cnt != 16'hFFFF) begin
        idle_cnt <= idle_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_elink_tx_gearbox.sv
// Bench for elink_tx_gearbox: four instances (W=2, W=4, W=8 MSB-first, W=1) share the
// word-side stimulus; a negedge monitor rebuilds 10-bit words from each enabled
// instance's serial stream and checks them against a queue of expected words.
module tb_elink_tx_gearbox;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic [9:0] din;
  logic       din_valid;
  logic       stats_clr;
  int         sel;
  logic       rdy_sel;

  logic [1:0] o2;
  logic [3:0] o4;
  logic [7:0] o8;
  logic [0:0] o1;
  logic [3:0] ia;
  logic [3:0] rds;
  logic [3:0] cerr;
`ifdef ELINK_TX_STATS_EN
  logic [15:0] dcnt [4];
  logic [15:0] icnt [4];
`endif

  int compared   = 0;
  int mismatched = 0;

  bit        mon_en [4];
  bit        bq     [4][$];
  bit [9:0]  expq   [4][$];

  always #5 clk = ~clk;

  elink_tx_gearbox_if if0 ();
  elink_tx_gearbox_if if1 ();
  elink_tx_gearbox_if if2 ();
  elink_tx_gearbox_if if3 ();

  assign if0.tx_en = tx_en;  assign if0.din = din;  assign if0.din_valid = din_valid;
  assign if1.tx_en = tx_en;  assign if1.din = din;  assign if1.din_valid = din_valid;
  assign if2.tx_en = tx_en;  assign if2.din = din;  assign if2.din_valid = din_valid;
  assign if3.tx_en = tx_en;  assign if3.din = din;  assign if3.din_valid = din_valid;

  always_comb begin
    case (sel)
      0:       rdy_sel = if0.din_ready;
      1:       rdy_sel = if1.din_ready;
      2:       rdy_sel = if2.din_ready;
      default: rdy_sel = if3.din_ready;
    endcase
  end

  elink_tx_gearbox #(.ELINK_WIDTH(2), .MSB_FIRST(1'b0)) dut0 (
    .bitCLK(clk), .rst(rst), .din_if(if0), .elink_out(o2),
    .idle_active(ia[0]), .rd_state(rds[0]), .code_err(cerr[0])
`ifdef ELINK_TX_STATS_EN
    , .stats_clr(stats_clr), .data_cnt(dcnt[0]), .idle_cnt(icnt[0])
`endif
  );

  elink_tx_gearbox #(.ELINK_WIDTH(4), .MSB_FIRST(1'b0)) dut1 (
    .bitCLK(clk), .rst(rst), .din_if(if1), .elink_out(o4),
    .idle_active(ia[1]), .rd_state(rds[1]), .code_err(cerr[1])
`ifdef ELINK_TX_STATS_EN
    , .stats_clr(stats_clr), .data_cnt(dcnt[1]), .idle_cnt(icnt[1])
`endif
  );

  elink_tx_gearbox #(.ELINK_WIDTH(8), .MSB_FIRST(1'b1)) dut2 (
    .bitCLK(clk), .rst(rst), .din_if(if2), .elink_out(o8),
    .idle_active(ia[2]), .rd_state(rds[2]), .code_err(cerr[2])
`ifdef ELINK_TX_STATS_EN
    , .stats_clr(stats_clr), .data_cnt(dcnt[2]), .idle_cnt(icnt[2])
`endif
  );

  elink_tx_gearbox #(.ELINK_WIDTH(1), .MSB_FIRST(1'b0)) dut3 (
    .bitCLK(clk), .rst(rst), .din_if(if3), .elink_out(o1),
    .idle_active(ia[3]), .rd_state(rds[3]), .code_err(cerr[3])
`ifdef ELINK_TX_STATS_EN
    , .stats_clr(stats_clr), .data_cnt(dcnt[3]), .idle_cnt(icnt[3])
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Append one slice (wire order) and compare every completed 10-bit word.
  task automatic mon_step(input int id, input logic [7:0] s, input int w, input bit msb);
    bit [9:0] wd;
    for (int i = 0; i < w; i++) begin
      bq[id].push_back(msb ? s[w-1-i] : s[i]);
    end
    while (bq[id].size() >= 10) begin
      wd = '0;
      for (int i = 0; i < 10; i++) begin
        wd[i] = bq[id].pop_front();
      end
      if (expq[id].size() != 0) begin
        check($sformatf("mon%0d_word", id), int'(wd), int'(expq[id].pop_front()));
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en[0]) mon_step(0, {6'd0, o2}, 2, 1'b0);
    if (mon_en[1]) mon_step(1, {4'd0, o4}, 4, 1'b0);
    if (mon_en[2]) mon_step(2, o8,         8, 1'b1);
    if (mon_en[3]) mon_step(3, {7'd0, o1}, 1, 1'b0);
  end

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 4; i++) begin
      mon_en[i] = 1'b0;
      bq[i].delete();
      expq[i].delete();
    end
  endtask

  // Returns at a negedge with rst just released; the next posedge is the first load.
  task automatic do_reset(input int id);
    clear_mon();
    sel = id;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int id, input int budget, input string name);
    int n;
    n = 0;
    while (expq[id].size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, expq[id].size(), 0);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy_sel && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(rdy_sel), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    int last;
    rst       = 1'b0;
    tx_en     = 1'b0;
    din_valid = 1'b1;
    din       = 10'h2AA;
    stats_clr = 1'b0;
    sel       = 0;
    clear_mon();

    // ---- Reset state, then W=2 idle fill with tx_en=0 ----
    #2 rst = 1'b1;
    #2;
    check("rst_elink_out", int'(o2), 0);
    check("rst_idle_active", int'(ia[0]), 0);
    check("rst_rd_state", int'(rds[0]), 0);
    check("rst_code_err", int'(cerr[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    edge_step();
    edge_step();
    mon_en[0] = 1'b1;
    expq[0].push_back(10'h17C); expq[0].push_back(10'h283);
    expq[0].push_back(10'h17C); expq[0].push_back(10'h283);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy_sel) hits++;
    end
    check("t1_ready_low", hits, 0);
    check("t1_idle_active", int'(ia[0]), 1);
    drain(0, 40, "t1_drain");

    // ---- W=2 continuous data after one idle ----
    tx_en = 1'b0; din_valid = 1'b1; din = 10'h2AA;
    do_reset(0);
    edge_step();
    edge_step();
    mon_en[0] = 1'b1;
    tx_en = 1'b1;
    expq[0].push_back(10'h17C);
    for (int i = 0; i < 5; i++) expq[0].push_back(10'h2AA);
    hits = 0;
    last = -1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rdy_sel) begin
        hits++;
        if (last >= 0) check("t2_ready_gap", i - last, 5);
        last = i;
      end
    end
    check("t2_ready_cnt", hits, 5);
    drain(0, 30, "t2_drain");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_slice", int'(o2), 2);
    end
    check("t2_rd_state", int'(rds[0]), 1);
    check("t2_idle_active", int'(ia[0]), 0);

    // ---- W=4 back-to-back words ----
    tx_en = 1'b1; din_valid = 1'b1; din = 10'h17C;
    do_reset(1);
    edge_step();
    din = 10'h2AA;
    edge_step();
    mon_en[1] = 1'b1;
    expq[1].push_back(10'h17C); expq[1].push_back(10'h2AA);
    expq[1].push_back(10'h283); expq[1].push_back(10'h155);
    expq[1].push_back(10'h17C);
    wait_ready("t3_ready_a"); edge_step();
    din = 10'h283;
    wait_ready("t3_ready_b"); edge_step();
    din = 10'h155;
    wait_ready("t3_ready_c"); edge_step();
    din_valid = 1'b0;
    check("t3_rd_state", int'(rds[1]), 0);
    check("t3_idle_active", int'(ia[1]), 0);
    drain(1, 60, "t3_drain");

    // ---- W=8 MSB-first, illegal word then idle ----
    tx_en = 1'b1; din_valid = 1'b1; din = 10'h001;
    do_reset(2);
    edge_step();
    din_valid = 1'b0;
    check("t4_code_err", int'(cerr[2]), 1);
    check("t4_rd_state", int'(rds[2]), 1);
    check("t4_idle_data", int'(ia[2]), 0);
    edge_step();
    mon_en[2] = 1'b1;
    expq[2].push_back(10'h001); expq[2].push_back(10'h283); expq[2].push_back(10'h17C);
    check("t4_idle_active", int'(ia[2]), 1);
    @(negedge clk);
    check("t4_first_slice", int'(o8), 8'h80);
    drain(2, 20, "t4_drain");
    check("t4_code_err_sticky", int'(cerr[2]), 1);

    // ---- W=2 reset mid-word ----
    tx_en = 1'b1; din_valid = 1'b1; din = 10'h2AA;
    do_reset(0);
    edge_step();
    edge_step();
    edge_step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_elink_out", int'(o2), 0);
    check("t5_idle_active", int'(ia[0]), 0);
    check("t5_rd_state", int'(rds[0]), 0);
    check("t5_code_err", int'(cerr[0]), 0);
    clear_mon();
    tx_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    edge_step();
    edge_step();
    mon_en[0] = 1'b1;
    expq[0].push_back(10'h17C); expq[0].push_back(10'h283);
    drain(0, 30, "t5_drain");

    // ---- W=1: three data words then idle ----
    tx_en = 1'b1; din_valid = 1'b1; din = 10'h2AA;
    do_reset(3);
    edge_step();
    din = 10'h155;
    edge_step();
    mon_en[3] = 1'b1;
    expq[3].push_back(10'h2AA); expq[3].push_back(10'h155);
    expq[3].push_back(10'h17C); expq[3].push_back(10'h283);
    expq[3].push_back(10'h17C);
    wait_ready("t6_ready_a"); edge_step();
    din = 10'h17C;
    wait_ready("t6_ready_b"); edge_step();
    din_valid = 1'b0;
    for (int i = 0; i < 40; i++) edge_step();
`ifdef ELINK_TX_STATS_EN
    check("t6_data_cnt", int'(dcnt[3]), 3);
    check("t6_idle_cnt", int'(icnt[3]), 4);
    stats_clr = 1'b1;
    edge_step();
    stats_clr = 1'b0;
    check("t6_data_clr", int'(dcnt[3]), 0);
    check("t6_idle_clr", int'(icnt[3]), 0);
`endif
    drain(3, 30, "t6_drain");
    check("t6_idle_active", int'(ia[3]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/elink_tx_gearbox.md
Name: elink_tx_gearbox

Overview:
- Parametrised transmit gearbox for the e-link path.
- Accepts 8b10b-encoded 10-bit words over a valid/ready handshake and emits ELINK_WIDTH bits per bitCLK cycle, with no gaps.
- When no data is offered, it inserts K28.5 idle commas at the correct running disparity.
- Sits between the encoder/FIFO read side and the e-link pads. Generalises the fixed 2-bit serialiser to 1/2/4/8-bit links, selectable bit order, and disparity-aware idle fill.

Parameters:
- ELINK_WIDTH, 2, bits emitted per cycle; legal values 1, 2, 4, 8 (elaboration error otherwise).
- MSB_FIRST, 0, 0: word bit 0 ('a') is transmitted first and appears on elink_out[0]; 1: the whole emitted slice is bit-reversed.
- IDLE_RDN, 10'h17C, K28.5 for RD- (abcdei fghj = 001111 1010, a at bit 0).
- IDLE_RDP, 10'h283, K28.5 for RD+.

Ports:
- bitCLK in 1: single clock, e-link bit-group rate.
- rst in 1: asynchronous, active-high reset.
- tx_en in 1: 0 forces idle fill; din_ready held low.
- din in 10: encoded word; bit 0 = 'a'.
- din_valid in 1: din is valid.
- din_ready out 1: the gearbox takes din this cycle (combinational).
- elink_out out ELINK_WIDTH: registered serial slice.
- idle_active out 1: registered; the last loaded word was an idle.
- rd_state out 1: registered running disparity; 0 = RD-, 1 = RD+.
- code_err out 1: sticky; a loaded word had a ones-count outside {4,5,6}.

Behaviour:
- State:
  - 18-bit shift buffer `sbuf`.
  - 5-bit `fill` (valid bits in sbuf).
  - rd, idle flag, err flag.
- Reset (async):
  - sbuf=0, fill=0, rd=0, elink_out=0, idle_active=0, code_err=0.
- Per cycle, evaluated in order:
  - Emit: if fill >= W:
    - elink_out <= sbuf[W-1:0], bit-reversed if MSB_FIRST.
    - sbuf >>= W; fill_n = fill - W.
    - Otherwise elink_out holds its value and fill_n = fill. This only happens in the first cycle after reset.
  - Load: if fill_n < W, append a 10-bit word at sbuf[fill_n +: 10]; fill <= fill_n + 10.
    - Word source is din if tx_en && din_valid, else IDLE_RDN when rd=0 / IDLE_RDP when rd=1.
    - Otherwise fill <= fill_n.
- din_ready = tx_en && (fill_n < W). A transfer occurs on the edge where din_valid && din_ready.
- Max fill is W-1+10 = 17; the buffer never overflows and never underruns after the first cycle.
- Disparity, updated on every load (data or idle):
  - ones(word)==5: rd unchanged.
  - ones is 4 or 6: rd toggles.
  - Any other count: rd toggles and code_err sets (sticky until reset).
- idle_active <= 1 on an idle load, 0 on a data load, unchanged when there is no load.
- Latency: a word loaded into an empty buffer at edge k has its first slice on elink_out after edge k+1. In steady state the word stream is contiguous with no inserted bits.
- Load cadence:
  - W=2: exactly one load every 5 cycles.
  - W=1: every 10 cycles.
  - W=4 and W=8: loads at non-uniform intervals averaging 10/W cycles.
- tx_en deasserted mid-stream: the word already in sbuf completes; the next load is an idle. No partial words are ever emitted.
- Reset mid-word: everything is cleared immediately. A partially sent word is lost, and the link restarts with an RD- comma.
- din_valid held while din_ready=0: no transfer, and din must be held stable.

Optional Feature:
- ELINK_TX_STATS_EN defined adds two outputs:
  - data_cnt[15:0]: count of data loads.
  - idle_cnt[15:0]: count of idle loads.
- Both counters saturate at 16'hFFFF, reset to 0 asynchronously, and clear synchronously on a new input stats_clr (1 bit). stats_clr has priority over the increment in the same cycle.
- Undefined: these ports and the counter logic are absent; the behaviour is otherwise identical.

Test Plan:
- W=2, tx_en=0 after reset: the serial stream repeats 0x17C,0x283 alternately (rd toggles every 5 cycles); idle_active=1; din_ready=0 throughout.
- W=2, tx_en=1, din=0x2AA (5 ones) valid continuously: din_ready pulses once every 5 cycles; elink_out repeats 2'b10; rd stays at its value from the last idle.
- W=4, words 0x17C,0x2AA,0x283,0x155 back-to-back: the reconstructed bitstream equals the concatenation LSB-first, with no gaps; loads occur at fill_n<4 points; final rd=0.
- W=8, MSB_FIRST=1, single word 0x001 (1 one) then idle: code_err=1 and rd toggles; the first slice shows bit 0 on elink_out[7]; idle follows at the flipped disparity.
- W=2, assert rst for 1 cycle mid-word: all outputs are 0 immediately; the first post-reset word is 0x17C.
- ELINK_TX_STATS_EN, W=1, 3 data words, then idle for 40 cycles: data_cnt=3, idle_cnt=4; stats_clr clears both to 0 on the next edge.
